// File: rtl/sdram_sched_pkg.sv
// Shared types for the SDRAM port scheduler: FSM state encoding and a one-hot
// to index helper.
package sdram_sched_pkg;

  localparam int unsigned MaxPorts = 8;

  typedef enum logic [2:0] {
    StIdle,
    StArb,
    StIssue,
    StBurst,
    StGap
  } sched_state_e;

  // OR-reduction encoder; the input is expected to be one-hot or zero.
  function automatic logic [2:0] onehot_to_idx(input logic [MaxPorts-1:0] oh);
    logic [2:0] idx;
    idx = '0;
    for (int i = 0; i < MaxPorts; i++) begin
      if (oh[i]) idx = idx | 3'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/rr_priority_pick.sv
// Combinational winner selection: lowest urgent requester, then the realtime
// port, then round-robin starting at the pointer.
module rr_priority_pick #(
  parameter int unsigned N       = 2,
  parameter int unsigned RT_PORT = 1,
  parameter int unsigned IdxW    = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]    req_i,
  input  logic [N-1:0]    urgent_i,
  input  logic [IdxW-1:0] ptr_i,
  output logic [IdxW-1:0] winner_o,
  output logic            valid_o
);

  localparam logic [IdxW-1:0] RtIdx = IdxW'(RT_PORT);

  logic [N-1:0]    urg_req;
  logic [IdxW-1:0] urg_idx;
  logic            urg_hit;
  logic [IdxW-1:0] rr_idx;
  logic            rr_hit;
  int unsigned     rr_pos;

  assign urg_req = req_i & urgent_i;

  // Scan downwards so the last hit, the lowest index, wins.
  always_comb begin
    urg_idx = '0;
    urg_hit = 1'b0;
    for (int i = N - 1; i >= 0; i--) begin
      if (urg_req[i]) begin
        urg_idx = IdxW'(i);
        urg_hit = 1'b1;
      end
    end
  end

  always_comb begin
    rr_idx = '0;
    rr_hit = 1'b0;
    rr_pos = 0;
    for (int k = N - 1; k >= 0; k--) begin
      rr_pos = (32'(ptr_i) + 32'(k)) % N;
      if (req_i[rr_pos[IdxW-1:0]]) begin
        rr_idx = rr_pos[IdxW-1:0];
        rr_hit = 1'b1;
      end
    end
  end

  always_comb begin
    if (urg_hit) begin
      winner_o = urg_idx;
      valid_o  = 1'b1;
    end else if (req_i[RtIdx]) begin
      winner_o = RtIdx;
      valid_o  = 1'b1;
    end else begin
      winner_o = rr_idx;
      valid_o  = rr_hit;
    end
  end

endmodule

// File: rtl/sdram_port_scheduler.sv
// Owns the shared SDRAM data port: arbitrates requesters, issues one start
// pulse per burst and holds the grant until the burst ends or the watchdog fires.
module sdram_port_scheduler
  import sdram_sched_pkg::*;
#(
  parameter int unsigned N             = 2,
  parameter int unsigned RT_PORT       = 1,
  parameter int unsigned AGE_LIMIT     = 64,
  parameter int unsigned BURST_TIMEOUT = 1024,
  parameter int unsigned IdxW          = (N > 1) ? $clog2(N) : 1
) (
  input  logic            clock,
  input  logic            reset,
  input  logic [N-1:0]    req,
  input  logic            ctrl_ready,
  input  logic            last_word,
  output logic [N-1:0]    grant,
  output logic [IdxW-1:0] grant_id,
  output logic            start,
  output logic [N-1:0]    urgent,
  output logic            timeout_err
);

  localparam int unsigned    AgeW   = $clog2(AGE_LIMIT + 1);
  localparam int unsigned    WdW    = $clog2(BURST_TIMEOUT + 1);
  localparam logic [AgeW-1:0] AgeMax = AgeW'(AGE_LIMIT);
  localparam logic [WdW-1:0]  WdMax  = WdW'(BURST_TIMEOUT);
  localparam logic [IdxW-1:0] LastIdx = IdxW'(N - 1);

  sched_state_e              state_q, state_d;
  logic [N-1:0]              grant_q, grant_d;
  logic [IdxW-1:0]           grant_id_q, grant_id_d;
  logic                      start_q, start_d;
  logic                      timeout_err_q, timeout_err_d;
  logic [IdxW-1:0]           ptr_q, ptr_d;
  logic [WdW-1:0]            wd_q, wd_d;
  logic [N-1:0][AgeW-1:0]    age_q, age_d;
  logic                      issue;
  logic [IdxW-1:0]           pick_idx;
  logic                      pick_valid;

  always_comb begin
    urgent = '0;
    for (int i = 0; i < N; i++) urgent[i] = (age_q[i] == AgeMax);
  end

  rr_priority_pick #(
    .N       (N),
    .RT_PORT (RT_PORT),
    .IdxW    (IdxW)
  ) u_pick (
    .req_i    (req),
    .urgent_i (urgent),
    .ptr_i    (ptr_q),
    .winner_o (pick_idx),
    .valid_o  (pick_valid)
  );

  always_comb begin
    state_d       = state_q;
    grant_d       = grant_q;
    start_d       = 1'b0;
    timeout_err_d = timeout_err_q;
    ptr_d         = ptr_q;
    wd_d          = wd_q;
    issue         = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (|req) state_d = StArb;
      end
      StArb: begin
        if (pick_valid) begin
          grant_d           = '0;
          grant_d[pick_idx] = 1'b1;
          state_d           = StIssue;
        end else begin
          state_d = StIdle;
        end
      end
      StIssue: begin
        if (!(|(req & grant_q))) begin
          grant_d = '0;
          state_d = StIdle;
        end else if (ctrl_ready) begin
          start_d = 1'b1;
          issue   = 1'b1;
          ptr_d   = (grant_id_q == LastIdx) ? '0 : grant_id_q + 1'b1;
          wd_d    = '0;
          state_d = StBurst;
        end
      end
      StBurst: begin
        wd_d = wd_q + 1'b1;
        // A last_word coinciding with expiry is a normal end.
        if (last_word) begin
          grant_d = '0;
          state_d = StGap;
        end else if (wd_d == WdMax) begin
          grant_d       = '0;
          timeout_err_d = 1'b1;
          state_d       = StGap;
        end
      end
      StGap: begin
        state_d = (|req) ? StArb : StIdle;
      end
      default: begin
        grant_d = '0;
        state_d = StIdle;
      end
    endcase

    grant_id_d = IdxW'(onehot_to_idx(MaxPorts'(grant_d)));

    for (int i = 0; i < N; i++) begin
      if (!req[i] || (issue && grant_q[i])) begin
        age_d[i] = '0;
      end else if (!grant_q[i] && (age_q[i] != AgeMax)) begin
        age_d[i] = age_q[i] + 1'b1;
      end else begin
        age_d[i] = age_q[i];
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q       <= StIdle;
      grant_q       <= '0;
      grant_id_q    <= '0;
      start_q       <= 1'b0;
      timeout_err_q <= 1'b0;
      ptr_q         <= '0;
      wd_q          <= '0;
      age_q         <= '0;
    end else begin
      state_q       <= state_d;
      grant_q       <= grant_d;
      grant_id_q    <= grant_id_d;
      start_q       <= start_d;
      timeout_err_q <= timeout_err_d;
      ptr_q         <= ptr_d;
      wd_q          <= wd_d;
      age_q         <= age_d;
    end
  end

  assign grant       = grant_q;
  assign grant_id    = grant_id_q;
  assign start       = start_q;
  assign timeout_err = timeout_err_q;

endmodule

// File: tb/tb_sdram_port_scheduler.sv
// Bench for sdram_port_scheduler: directed scenarios with literal expectations
// plus randomized traffic compared every cycle against a behavioural model.
module tb_sdram_port_scheduler;

  localparam int N             = 4;
  localparam int RT_PORT       = 3;
  localparam int AGE_LIMIT     = 20;
  localparam int BURST_TIMEOUT = 16;

  localparam int PIdle  = 0;
  localparam int PArb   = 1;
  localparam int PIssue = 2;
  localparam int PBurst = 3;
  localparam int PGap   = 4;

  logic         clock = 1'b0;
  logic         reset = 1'b0;
  logic [N-1:0] req = '0;
  logic         ctrl_ready = 1'b0;
  logic         last_word = 1'b0;
  logic [N-1:0] grant;
  logic [1:0]   grant_id;
  logic         start;
  logic [N-1:0] urgent;
  logic         timeout_err;

  int errors = 0;
  int checks = 0;

  // Behavioural model state.
  int m_phase = PIdle;
  int m_owner = -1;
  int m_last  = N - 1;
  int m_bcnt  = 0;
  bit m_start = 1'b0;
  bit m_err   = 1'b0;
  int m_age [N];

  sdram_port_scheduler #(
    .N             (N),
    .RT_PORT       (RT_PORT),
    .AGE_LIMIT     (AGE_LIMIT),
    .BURST_TIMEOUT (BURST_TIMEOUT)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .req         (req),
    .ctrl_ready  (ctrl_ready),
    .last_word   (last_word),
    .grant       (grant),
    .grant_id    (grant_id),
    .start       (start),
    .urgent      (urgent),
    .timeout_err (timeout_err)
  );

  always #5 clock = ~clock;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int pick();
    for (int i = 0; i < N; i++) if (req[i] && m_age[i] == AGE_LIMIT) return i;
    if (req[RT_PORT]) return RT_PORT;
    for (int k = 0; k < N; k++) if (req[(m_last + 1 + k) % N]) return (m_last + 1 + k) % N;
    return -1;
  endfunction

  task automatic model_reset();
    m_phase = PIdle;
    m_owner = -1;
    m_last  = N - 1;
    m_bcnt  = 0;
    m_start = 1'b0;
    m_err   = 1'b0;
    for (int i = 0; i < N; i++) m_age[i] = 0;
  endtask

  task automatic model_step();
    int w;
    bit issue_now;
    w = pick();
    issue_now = (m_phase == PIssue) && req[m_owner] && ctrl_ready;
    for (int i = 0; i < N; i++) begin
      if (!req[i] || (issue_now && m_owner == i)) m_age[i] = 0;
      else if (m_owner != i && m_age[i] < AGE_LIMIT) m_age[i]++;
    end
    m_start = 1'b0;
    case (m_phase)
      PIdle: if (req != 0) m_phase = PArb;
      PArb: begin
        if (w >= 0) begin
          m_owner = w;
          m_phase = PIssue;
        end else m_phase = PIdle;
      end
      PIssue: begin
        if (!req[m_owner]) begin
          m_owner = -1;
          m_phase = PIdle;
        end else if (ctrl_ready) begin
          m_start = 1'b1;
          m_last  = m_owner;
          m_bcnt  = 0;
          m_phase = PBurst;
        end
      end
      PBurst: begin
        m_bcnt++;
        if (last_word || m_bcnt == BURST_TIMEOUT) begin
          if (!last_word) m_err = 1'b1;
          m_owner = -1;
          m_phase = PGap;
        end
      end
      default: m_phase = (req != 0) ? PArb : PIdle;
    endcase
  endtask

  always @(posedge clock or negedge reset) begin
    if (!reset) model_reset();
    else model_step();
  end

  always @(negedge clock) begin
    logic [N-1:0] eg, eu;
    if (reset) begin
      eg = '0;
      eu = '0;
      if (m_owner >= 0) eg[m_owner] = 1'b1;
      for (int i = 0; i < N; i++) eu[i] = (m_age[i] == AGE_LIMIT);
      chk("m_grant", grant, eg);
      chk("m_grant_id", grant_id, (m_owner >= 0) ? m_owner : 0);
      chk("m_start", start, m_start);
      chk("m_urgent", urgent, eu);
      chk("m_timeout_err", timeout_err, m_err);
      chk("onehot_grant", $onehot0(grant), 1);
      chk("start_needs_grant", start && (grant == 0), 0);
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic wait_start(input string name);
    int n;
    n = 0;
    while (start !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    chk(name, start, 1);
  endtask

  task automatic idle_out();
    req = '0;
    ctrl_ready = 1'b0;
    last_word = 1'b0;
    repeat (4) tick();
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end

  initial begin
    int n_rt, n, ids[4], got;
    bit got0;
    logic [N-1:0] prev, r;

    #3;
    chk("rst_grant", grant, 0);
    chk("rst_grant_id", grant_id, 0);
    chk("rst_start", start, 0);
    chk("rst_urgent", urgent, 0);
    chk("rst_timeout_err", timeout_err, 0);
    #9 reset = 1'b1;
    tick();

    // Single request latency.
    req = 4'b0001;
    ctrl_ready = 1'b1;
    tick();
    chk("single_arb_nogrant", grant, 0);
    tick();
    chk("single_grant", grant, 4'b0001);
    chk("single_nostart_yet", start, 0);
    tick();
    chk("single_start", start, 1);
    tick();
    chk("single_start_pulse", start, 0);
    chk("single_grant_held", grant, 4'b0001);
    repeat (6) tick();
    last_word = 1'b1;
    req = '0;
    tick();
    chk("single_release", grant, 0);
    idle_out();

    // Realtime priority until port 0 ages out.
    req = 4'b1001;
    ctrl_ready = 1'b1;
    last_word = 1'b1;
    n_rt = 0;
    got0 = 1'b0;
    for (int c = 0; c < 200 && !got0; c++) begin
      prev = grant;
      tick();
      if (prev == 0 && grant != 0) begin
        if (grant_id == 2'd3) n_rt++;
        else begin
          got0 = 1'b1;
          chk("rt_urgent_winner", grant_id, 0);
          chk("rt_urgent_flags", urgent, 4'b0001);
          req = '0;
        end
      end
    end
    chk("rt_grants_before_urgent", n_rt, 5);
    chk("rt_urgent_reached", got0, 1);
    idle_out();

    // Round-robin among 0..2.
    req = 4'b0111;
    ctrl_ready = 1'b1;
    last_word = 1'b1;
    got = 0;
    for (int c = 0; c < 100 && got < 4; c++) begin
      prev = grant;
      tick();
      if (prev == 0 && grant != 0) begin
        ids[got] = grant_id;
        got++;
        if (got == 4) req = '0;
      end
    end
    chk("rr_count", got, 4);
    chk("rr_0", ids[0], 0);
    chk("rr_1", ids[1], 1);
    chk("rr_2", ids[2], 2);
    chk("rr_3", ids[3], 0);
    idle_out();

    // Abandon before start leaves the pointer after port 2.
    req = 4'b0001;
    tick();
    tick();
    chk("ab_grant", grant, 4'b0001);
    tick();
    chk("ab_wait_grant", grant, 4'b0001);
    chk("ab_wait_nostart", start, 0);
    req = '0;
    tick();
    chk("ab_released", grant, 0);
    chk("ab_nostart", start, 0);
    tick();
    req = 4'b0011;
    ctrl_ready = 1'b1;
    tick();
    tick();
    chk("ab_ptr_kept_grant", grant, 4'b0001);
    chk("ab_ptr_kept_id", grant_id, 0);
    last_word = 1'b1;
    tick();
    req = '0;
    idle_out();

    // Watchdog.
    req = 4'b0001;
    ctrl_ready = 1'b1;
    wait_start("wd_start");
    n = 0;
    for (int c = 0; c < 40; c++) begin
      tick();
      n++;
      if (grant == 0) break;
    end
    chk("wd_cycles", n, 16);
    chk("wd_err", timeout_err, 1);
    idle_out();
    chk("wd_err_sticky", timeout_err, 1);
    #2 reset = 1'b0;
    #1 chk("wd_err_cleared", timeout_err, 0);
    #3 reset = 1'b1;
    tick();

    // Asynchronous reset mid-burst.
    req = 4'b0010;
    ctrl_ready = 1'b1;
    wait_start("ar_start");
    #2 reset = 1'b0;
    #1;
    chk("ar_grant", grant, 0);
    chk("ar_start_low", start, 0);
    #3 reset = 1'b1;
    idle_out();

    // Randomized traffic.
    for (int c = 0; c < 3000; c++) begin
      r = req;
      for (int i = 0; i < N; i++) begin
        if (!r[i]) begin
          if ($urandom_range(3) == 0) r[i] = 1'b1;
        end else if (m_owner == i) begin
          if (m_phase == PIssue && $urandom_range(15) == 0) r[i] = 1'b0;
          else if (m_phase == PBurst && $urandom_range(7) == 0) r[i] = 1'b0;
        end else if (m_last == i) begin
          if ($urandom_range(1) == 0) r[i] = 1'b0;
        end else if ($urandom_range(23) == 0) begin
          r[i] = 1'b0;
        end
      end
      req = r;
      ctrl_ready = ($urandom_range(3) != 0);
      last_word = ($urandom_range(5) == 0);
      tick();
    end
    idle_out();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
